// File: rtl/alu_instr_sequencer.sv
// Front-end sequencer for the combinational ALU: accepts ARM-style instructions,
// decodes them, checks the condition against held NZCV and runs decode/exec/writeback.
module alu_instr_sequencer #(
  parameter logic [3:0] PC_REG      = 4'd15,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  alu_cmd,
  output logic [1:0]  alu_op,
  output logic        alu_valid,
  input  logic [3:0]  alu_flags_in,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rm_addr,
  output logic [3:0]  rd_addr,
  output logic        imm_sel,
  output logic [31:0] imm_value,
  output logic        reg_we,
  output logic [3:0]  flags_q,
  output logic        cond_fail,
  output logic        illegal_instr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t     state_reg;
  logic [7:0] op_cmd_s_reg;  // {op, I, cmd, S} of the captured instruction

  logic [3:0]  cond_f;
  logic [1:0]  op_f;
  logic        i_f;
  logic [3:0]  cmd_f;
  logic [3:0]  rn_f;
  logic [3:0]  rd_f;
  logic [11:0] op2_f;

  assign cond_f = instr[31:28];
  assign op_f   = instr[27:26];
  assign i_f    = instr[25];
  assign cmd_f  = instr[24:21];
  assign rn_f   = instr[19:16];
  assign rd_f   = instr[15:12];
  assign op2_f  = instr[11:0];

  // Rotate the zero-extended imm8 right by twice the 4-bit rotate field.
  function automatic logic [31:0] rotate_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] doubled;
    doubled = {24'd0, imm8, 24'd0, imm8};
    return 32'(doubled >> {rot, 1'b0});
  endfunction

  logic cond_pass_next;
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass_next = 1'b0;
    case (cond_f)
      4'b0000: cond_pass_next = flag_z;
      4'b0001: cond_pass_next = !flag_z;
      4'b0010: cond_pass_next = flag_c;
      4'b0011: cond_pass_next = !flag_c;
      4'b0100: cond_pass_next = flag_n;
      4'b0101: cond_pass_next = !flag_n;
      4'b0110: cond_pass_next = flag_v;
      4'b0111: cond_pass_next = !flag_v;
      4'b1000: cond_pass_next = flag_c && !flag_z;
      4'b1001: cond_pass_next = !flag_c || flag_z;
      4'b1010: cond_pass_next = (flag_n == flag_v);
      4'b1011: cond_pass_next = (flag_n != flag_v);
      4'b1100: cond_pass_next = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass_next = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass_next = 1'b1;
      default: cond_pass_next = 1'b0;
    endcase
  end

  logic        legal_cmd_next;
  logic        illegal_next;
  logic [3:0]  alu_cmd_next;
  logic [3:0]  rn_addr_next;
  logic [3:0]  rm_addr_next;
  logic [3:0]  rd_addr_next;
  logic        imm_sel_next;
  logic [31:0] imm_value_next;

  always_comb begin
    legal_cmd_next = 1'b0;
    case (cmd_f)
      4'b0000, 4'b0001, 4'b1100, 4'b0010,
      4'b0011, 4'b0100, 4'b1010: legal_cmd_next = 1'b1;
      default: legal_cmd_next = 1'b0;
    endcase
  end

  always_comb begin
    illegal_next   = 1'b0;
    alu_cmd_next   = cmd_f;
    rn_addr_next   = rn_f;
    rm_addr_next   = 4'd0;
    rd_addr_next   = rd_f;
    imm_sel_next   = 1'b0;
    imm_value_next = 32'd0;
    case (op_f)
      2'b00: begin
        illegal_next = !legal_cmd_next;
        if (i_f) begin
          imm_sel_next   = 1'b1;
          imm_value_next = rotate_imm(op2_f[7:0], op2_f[11:8]);
        end else begin
          rm_addr_next = op2_f[3:0];
        end
      end
      2'b01: begin
        alu_cmd_next   = {instr[23], 3'b000};
        imm_sel_next   = 1'b1;
        imm_value_next = {20'd0, op2_f};
      end
      2'b10: begin
        alu_cmd_next   = 4'b0000;
        rn_addr_next   = PC_REG;
        rd_addr_next   = PC_REG;
        imm_sel_next   = 1'b1;
        imm_value_next = {{6{instr[23]}}, instr[23:0], 2'b00};
      end
      default: illegal_next = 1'b1;
    endcase
  end

  logic ex_is_cmp;
  logic ex_flag_upd;
  assign ex_is_cmp   = (op_cmd_s_reg[7:6] == 2'b00) && (op_cmd_s_reg[4:1] == 4'b1010);
  assign ex_flag_upd = (op_cmd_s_reg[7:6] == 2'b00) && (op_cmd_s_reg[0] || ex_is_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_cmd_s_reg  <= 8'd0;
      instr_ready   <= 1'b0;
      alu_cmd       <= 4'd0;
      alu_op        <= 2'd0;
      alu_valid     <= 1'b0;
      rn_addr       <= 4'd0;
      rm_addr       <= 4'd0;
      rd_addr       <= 4'd0;
      imm_sel       <= 1'b0;
      imm_value     <= 32'd0;
      reg_we        <= 1'b0;
      flags_q       <= FLAGS_RESET;
      cond_fail     <= 1'b0;
      illegal_instr <= 1'b0;
      busy          <= 1'b0;
    end else begin
      cond_fail     <= 1'b0;
      illegal_instr <= 1'b0;
      alu_valid     <= 1'b0;
      reg_we        <= 1'b0;
      case (state_reg)
        IDLE: begin
          instr_ready <= 1'b1;
          // Decode is registered at capture so DECODE-cycle outputs are already valid.
          if (instr_valid && instr_ready) begin
            op_cmd_s_reg  <= instr[27:20];
            alu_cmd       <= alu_cmd_next;
            alu_op        <= op_f;
            rn_addr       <= rn_addr_next;
            rm_addr       <= rm_addr_next;
            rd_addr       <= rd_addr_next;
            imm_sel       <= imm_sel_next;
            imm_value     <= imm_value_next;
            cond_fail     <= !cond_pass_next;
            illegal_instr <= cond_pass_next && illegal_next;
            instr_ready   <= 1'b0;
            busy          <= 1'b1;
            state_reg     <= DECODE;
          end
        end
        DECODE: begin
          if (cond_fail || illegal_instr) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            alu_valid <= 1'b1;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          if (ex_flag_upd) begin
            flags_q <= alu_flags_in;
          end
          reg_we    <= !ex_is_cmp;
          state_reg <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer: expectations queued at issue, popped when the DUT responds.
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_cmd;
  logic [1:0]  alu_op;
  logic        alu_valid;
  logic [3:0]  alu_flags_in;
  logic [3:0]  rn_addr, rm_addr, rd_addr;
  logic        imm_sel;
  logic [31:0] imm_value;
  logic        reg_we;
  logic [3:0]  flags_q;
  logic        cond_fail;
  logic        illegal_instr;
  logic        busy;

  alu_instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_cmd(alu_cmd), .alu_op(alu_op),
    .alu_valid(alu_valid), .alu_flags_in(alu_flags_in), .rn_addr(rn_addr),
    .rm_addr(rm_addr), .rd_addr(rd_addr), .imm_sel(imm_sel),
    .imm_value(imm_value), .reg_we(reg_we), .flags_q(flags_q),
    .cond_fail(cond_fail), .illegal_instr(illegal_instr), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // kind: 0 executed, 1 condition skipped, 2 illegal, 3 no response
  typedef struct packed {
    logic [1:0]  kind;
    logic [50:0] dec;
    logic [50:0] mask;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk_exec(input logic [3:0] cmd, input logic [1:0] op,
                                   input logic [3:0] rn, input logic [3:0] rm,
                                   input logic [3:0] rd, input logic sel,
                                   input logic [31:0] imm, input bit chk_rm, input bit chk_imm);
    exp_t e;
    e.kind = 2'd0;
    e.dec  = {cmd, op, rn, rm, rd, sel, imm};
    e.mask = {4'hF, 2'h3, 4'hF, chk_rm ? 4'hF : 4'h0, 4'hF, 1'b1, chk_imm ? 32'hFFFF_FFFF : 32'h0};
    return e;
  endfunction

  function automatic exp_t mk_skip(input logic [1:0] kind);
    exp_t e;
    e = '0;
    e.kind = kind;
    return e;
  endfunction

  function automatic logic [31:0] dp(input logic [3:0] cond, input logic i, input logic [3:0] cmd,
                                     input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] op2);
    return {cond, 2'b00, i, cmd, s, rn, rd, op2};
  endfunction

  function automatic logic [31:0] br(input logic [3:0] cond, input logic [23:0] off);
    return {cond, 2'b10, 2'b00, off};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for instr_ready, offers one instruction for one cycle, queues its expectation.
  task automatic send(input logic [31:0] ins, input exp_t e, output bit ok);
    int n = 0;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    ok = instr_ready;
    if (ok) begin
      instr       = ins;
      instr_valid = 1'b1;
      exp_q.push_back(e);
      step();
      instr_valid = 1'b0;
    end
  endtask

  // Called at cycle 1; returns at cycle 1 for a pulse response, at cycle 2 otherwise.
  task automatic observe_result(output exp_t e, output logic [1:0] kind, output logic [50:0] dec);
    e = mk_skip(2'd3);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    if (cond_fail) kind = 2'd1;
    else if (illegal_instr) kind = 2'd2;
    else begin
      step();
      kind = alu_valid ? 2'd0 : 2'd3;
    end
    dec = {alu_cmd, alu_op, rn_addr, rm_addr, rd_addr, imm_sel, imm_value};
    $display("[TB] txn instr=%h kind=%0d want=%0d dec=%h", instr, kind, e.kind, dec);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; alu_flags_in = 4'd0;
    repeat (3) step();
    n_tests++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
    n_tests++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags_q); end
    n_tests++; if ({busy, alu_valid, reg_we, cond_fail, illegal_instr, imm_value} !== 37'd0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b av=%b we=%b cf=%b il=%b imm=%h want all 0",
                         busy, alu_valid, reg_we, cond_fail, illegal_instr, imm_value); end
    rst_n = 1'b1;
    step();
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", instr_ready); end
  endtask

  task automatic test_add();
    exp_t e; logic [1:0] kind; logic [50:0] dec; bit ok;
    alu_flags_in = 4'b0100;
    send(dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'd2, 12'h005),
         mk_exec(4'b0100, 2'b00, 4'd1, 4'd0, 4'd2, 1'b1, 32'd5, 1'b0, 1'b1), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL add_accept: got ready=0 want 1"); end
    n_tests++; if ({busy, instr_ready, alu_valid} !== 3'b100) begin
      n_fail++; $display("FAIL add_cycle1: got busy/ready/av=%b want 100", {busy, instr_ready, alu_valid}); end
    observe_result(e, kind, dec);
    n_tests++; if (kind !== e.kind) begin n_fail++; $display("FAIL add_kind: got %0d want %0d", kind, e.kind); end
    n_tests++; if ((dec & e.mask) !== (e.dec & e.mask)) begin n_fail++; $display("FAIL add_decode: got %h want %h", dec & e.mask, e.dec & e.mask); end
    step();
    n_tests++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL add_reg_we_c3: got %b want 1", reg_we); end
    n_tests++; if (flags_q !== 4'b0100) begin n_fail++; $display("FAIL add_flags: got %b want 0100", flags_q); end
    step();
    n_tests++; if ({instr_ready, reg_we, busy} !== 3'b100) begin
      n_fail++; $display("FAIL add_cycle4: got ready/we/busy=%b want 100", {instr_ready, reg_we, busy}); end
  endtask

  task automatic test_cmp_beq();
    exp_t e; logic [1:0] kind; logic [50:0] dec; bit ok;
    alu_flags_in = 4'b0110;
    send(dp(4'hE, 1'b0, 4'b1010, 1'b0, 4'd3, 4'd0, 12'h004),
         mk_exec(4'b1010, 2'b00, 4'd3, 4'd4, 4'd0, 1'b0, 32'd0, 1'b1, 1'b0), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cmp_accept: got ready=0 want 1"); end
    observe_result(e, kind, dec);
    n_tests++; if (kind !== e.kind) begin n_fail++; $display("FAIL cmp_kind: got %0d want %0d", kind, e.kind); end
    n_tests++; if ((dec & e.mask) !== (e.dec & e.mask)) begin n_fail++; $display("FAIL cmp_decode: got %h want %h", dec & e.mask, e.dec & e.mask); end
    step();
    n_tests++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL cmp_no_reg_we: got %b want 0", reg_we); end
    n_tests++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL cmp_flags: got %b want 0110", flags_q); end
    step();
    alu_flags_in = 4'b1001;
    send(br(4'h0, 24'hFF_FFFF), mk_exec(4'b0000, 2'b10, 4'd15, 4'd0, 4'd15, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL beq_accept: got ready=0 want 1"); end
    observe_result(e, kind, dec);
    n_tests++; if (kind !== e.kind) begin n_fail++; $display("FAIL beq_kind: got %0d want %0d", kind, e.kind); end
    n_tests++; if ((dec & e.mask) !== (e.dec & e.mask)) begin n_fail++; $display("FAIL beq_decode: got %h want %h", dec & e.mask, e.dec & e.mask); end
    step();
    n_tests++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL beq_reg_we: got %b want 1", reg_we); end
    n_tests++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL beq_flags_kept: got %b want 0110", flags_q); end
    step();
  endtask

  // flags_q = 0110 (N=0 Z=1 C=1 V=0): conditions that pass are EQ CS PL VC LS GE LE AL.
  task automatic test_conditions();
    exp_t e; logic [1:0] kind; logic [50:0] dec; bit ok;
    logic [15:0] pass_tbl;
    pass_tbl = 16'h66A5;
    alu_flags_in = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      send(br(c[3:0], 24'h00_0010),
           pass_tbl[c] ? mk_exec(4'b0000, 2'b10, 4'd15, 4'd0, 4'd15, 1'b1, 32'h40, 1'b0, 1'b1) : mk_skip(2'd1), ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL cond%0d_accept: got ready=0 want 1", c); end
      observe_result(e, kind, dec);
      n_tests++; if (kind !== e.kind) begin n_fail++; $display("FAIL cond%0d_kind: got %0d want %0d", c, kind, e.kind); end
      if (kind == 2'd0) begin
        step();
        step();
      end else begin
        step();
        n_tests++; if ({instr_ready, alu_valid, cond_fail} !== 3'b100) begin
          n_fail++; $display("FAIL cond%0d_skip_c2: got ready/av/cf=%b want 100", c, {instr_ready, alu_valid, cond_fail}); end
      end
    end
    n_tests++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL cond_flags_kept: got %b want 0110", flags_q); end
  endtask

  task automatic test_rotate_illegal();
    exp_t e; logic [1:0] kind; logic [50:0] dec; bit ok;
    alu_flags_in = 4'b1001;
    send(dp(4'hE, 1'b1, 4'b1100, 1'b0, 4'd5, 4'd6, 12'h4FF),
         mk_exec(4'b1100, 2'b00, 4'd5, 4'd0, 4'd6, 1'b1, 32'hFF00_0000, 1'b0, 1'b1), ok);
    observe_result(e, kind, dec);
    n_tests++; if ((dec & e.mask) !== (e.dec & e.mask) || kind !== e.kind) begin
      n_fail++; $display("FAIL rot4_decode: got kind=%0d %h want kind=%0d %h", kind, dec & e.mask, e.kind, e.dec & e.mask); end
    step(); step();
    send(dp(4'hE, 1'b1, 4'b0000, 1'b0, 4'd7, 4'd8, 12'h103),
         mk_exec(4'b0000, 2'b00, 4'd7, 4'd0, 4'd8, 1'b1, 32'hC000_0000, 1'b0, 1'b1), ok);
    observe_result(e, kind, dec);
    n_tests++; if ((dec & e.mask) !== (e.dec & e.mask) || kind !== e.kind) begin
      n_fail++; $display("FAIL rot1_decode: got kind=%0d %h want kind=%0d %h", kind, dec & e.mask, e.kind, e.dec & e.mask); end
    step();
    n_tests++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL rot_no_flag_load: got %b want 0110", flags_q); end
    step();
    alu_flags_in = 4'b1111;
    send(dp(4'hE, 1'b0, 4'b0110, 1'b1, 4'd1, 4'd1, 12'h001), mk_skip(2'd2), ok);
    observe_result(e, kind, dec);
    n_tests++; if (kind !== e.kind) begin n_fail++; $display("FAIL illegal_cmd_kind: got %0d want %0d", kind, e.kind); end
    step();
    n_tests++; if ({instr_ready, illegal_instr, alu_valid, flags_q} !== 7'b100_0110) begin
      n_fail++; $display("FAIL illegal_cmd_c2: got ready/il/av/flags=%b want 1000110", {instr_ready, illegal_instr, alu_valid, flags_q}); end
    send({4'hE, 2'b11, 26'h000_0000}, mk_skip(2'd2), ok);
    observe_result(e, kind, dec);
    n_tests++; if (kind !== e.kind) begin n_fail++; $display("FAIL illegal_op_kind: got %0d want %0d", kind, e.kind); end
    step();
    n_tests++; if ({instr_ready, reg_we, flags_q} !== 6'b10_0110) begin
      n_fail++; $display("FAIL illegal_op_c2: got ready/we/flags=%b want 100110", {instr_ready, reg_we, flags_q}); end
  endtask

  task automatic test_mem();
    exp_t e; logic [1:0] kind; logic [50:0] dec; bit ok;
    alu_flags_in = 4'b1111;
    send({4'hE, 2'b01, 1'b0, 4'b0100, 1'b1, 4'd9, 4'd10, 12'hABC},
         mk_exec(4'b1000, 2'b01, 4'd9, 4'd0, 4'd10, 1'b1, 32'h0000_0ABC, 1'b0, 1'b1), ok);
    observe_result(e, kind, dec);
    n_tests++; if ((dec & e.mask) !== (e.dec & e.mask) || kind !== e.kind) begin
      n_fail++; $display("FAIL mem_decode: got kind=%0d %h want kind=%0d %h", kind, dec & e.mask, e.kind, e.dec & e.mask); end
    step();
    n_tests++; if ({reg_we, flags_q} !== 5'b1_0110) begin
      n_fail++; $display("FAIL mem_wb: got we/flags=%b want 10110", {reg_we, flags_q}); end
    step();
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [1:0] kind; logic [50:0] dec; bit ok;
    alu_flags_in = 4'b1111;
    send(dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'd2, 12'h001),
         mk_exec(4'b0100, 2'b00, 4'd1, 4'd0, 4'd2, 1'b1, 32'd1, 1'b0, 1'b1), ok);
    observe_result(e, kind, dec);
    n_tests++; if (kind !== e.kind) begin n_fail++; $display("FAIL rstmid_kind: got %0d want %0d", kind, e.kind); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({reg_we, alu_valid, busy, instr_ready, flags_q} !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_abort: got we/av/busy/ready/flags=%b want 00000000", {reg_we, alu_valid, busy, instr_ready, flags_q}); end
    step();
    n_tests++; if ({reg_we, instr_ready} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_held: got we/ready=%b want 00", {reg_we, instr_ready}); end
    rst_n = 1'b1;
    step();
    n_tests++; if ({instr_ready, reg_we, flags_q} !== 6'b10_0000) begin
      n_fail++; $display("FAIL rstmid_release: got ready/we/flags=%b want 100000", {instr_ready, reg_we, flags_q}); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int n = 0; int n_av = 0; int n_we = 0;
    logic [50:0] dec;
    alu_flags_in = 4'b0000;
    while (!instr_ready && n < 20) begin step(); n++; end
    instr       = dp(4'hE, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd3, 12'h007);
    instr_valid = 1'b1;
    exp_q.push_back(mk_exec(4'b0100, 2'b00, 4'd2, 4'd7, 4'd3, 1'b0, 32'd0, 1'b1, 1'b0));
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 3) instr_valid = 1'b0;
      if (alu_valid) begin
        n_av++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          dec = {alu_cmd, alu_op, rn_addr, rm_addr, rd_addr, imm_sel, imm_value};
          $display("[TB] txn instr=%h kind=0 dec=%h", instr, dec);
          n_tests++; if ((dec & e.mask) !== (e.dec & e.mask)) begin
            n_fail++; $display("FAIL b2b_decode: got %h want %h", dec & e.mask, e.dec & e.mask); end
        end
      end
      if (reg_we) n_we++;
    end
    n_tests++; if (n_av !== 1) begin n_fail++; $display("FAIL b2b_captures: got %0d alu_valid pulses want 1", n_av); end
    n_tests++; if (n_we !== 1) begin n_fail++; $display("FAIL b2b_writebacks: got %0d reg_we pulses want 1", n_we); end
    n_tests++; if ({busy, instr_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_idle: got busy/ready=%b want 01", {busy, instr_ready}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp_beq();
    test_conditions();
    test_rotate_illegal();
    test_mem();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
